// File: rtl/gmm_pkg.sv
// gmm_pkg -- constants shared by the GMM scoring core and its sequencer.
//
// Contents:
//   LOG_ZERO           log-domain "minus infinity" seed for every senone score
//   *_DEF              default frame geometry (features, components, senones)
//   rec_stride/off_*   layout of one component record in parameter memory:
//                      means, then precisions, then weight, then factor
//   ST_*               sequencer state encodings
//   fp_gt              ordered compare of two IEEE-754 singles
package gmm_pkg;

    localparam logic [31:0] LOG_ZERO = 32'hFF7FFFFF;

    localparam int FEAT_SIZE_DEF   = 29;
    localparam int COMP_SIZE_DEF   = 32;
    localparam int SENONE_SIZE_DEF = 5120;

    localparam int OFF_MEAN = 0;

    // Words per component record.
    function automatic int rec_stride(input int feat);
        return 2 * feat + 2;
    endfunction

    function automatic int off_prec(input int feat);
        return feat;
    endfunction

    function automatic int off_weight(input int feat);
        return 2 * feat;
    endfunction

    function automatic int off_factor(input int feat);
        return 2 * feat + 1;
    endfunction

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD_FEAT = 3'd1;
    localparam logic [2:0] ST_FETCH     = 3'd2;
    localparam logic [2:0] ST_CORE      = 3'd3;
    localparam logic [2:0] ST_OUT       = 3'd4;

    // Maps a sign-magnitude float onto an unsigned key whose integer order
    // matches the numeric order. Both zeros map to the same key so that
    // -0 and +0 compare equal.
    function automatic logic [31:0] fp_order_key(input logic [31:0] x);
        if (x[30:0] == 31'd0) begin
            return 32'h80000000;
        end else if (x[31]) begin
            return ~x;
        end else begin
            return x | 32'h80000000;
        end
    endfunction

    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        return fp_order_key(a) > fp_order_key(b);
    endfunction

endpackage

// File: rtl/gmm_param_fetch.sv
// gmm_param_fetch -- reads one component record from parameter memory.
//
// While fetch_en is high it issues rec_stride(FEAT_SIZE) reads, one per
// cycle, at consecutive addresses starting from base_addr, then stops.
// Returned words are counted (never assumed) and steered by their return
// position into the mean / precision / weight / factor registers.
// fetch_done pulses on the cycle the final word is captured. Dropping
// fetch_en clears both counters, so the next record starts cleanly and any
// late rvalid outside a fetch is ignored.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   fetch_en       high while the sequencer is in its fetch state
//   base_addr      word address of the record
//   mem_rd_en      read request (one word per cycle)
//   mem_addr       read address (0 when not requesting)
//   mem_rdata      returned word
//   mem_rvalid     returned word valid, in issue order, any latency
//   mean, prec     FEAT_SIZE packed 32-bit words, dimension i at [32i+31:32i]
//   weight, factor per-component scalars
//   fetch_done     last word of the record captured this cycle
module gmm_param_fetch
    import gmm_pkg::*;
#(
    parameter int FEAT_SIZE = FEAT_SIZE_DEF,
    parameter int ADDR_W    = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fetch_en,
    input  logic [ADDR_W-1:0]         base_addr,
    output logic                      mem_rd_en,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [31:0]               mem_rdata,
    input  logic                      mem_rvalid,
    output logic [32*FEAT_SIZE-1:0]   mean,
    output logic [32*FEAT_SIZE-1:0]   prec,
    output logic [31:0]               weight,
    output logic [31:0]               factor,
    output logic                      fetch_done
);

    localparam int R  = rec_stride(FEAT_SIZE);
    localparam int CW = $clog2(R + 1);

    logic [CW-1:0] iss_cnt;
    logic [CW-1:0] ret_cnt;
    logic          ret_ok;

    assign mem_rd_en  = fetch_en && (iss_cnt < CW'(R));
    assign mem_addr   = mem_rd_en ? (base_addr + ADDR_W'(iss_cnt)) : '0;
    assign ret_ok     = fetch_en && mem_rvalid && (ret_cnt < CW'(R));
    assign fetch_done = ret_ok && (ret_cnt == CW'(R - 1));

    // Issue and return counters; held at zero outside a fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_cnt <= '0;
            ret_cnt <= '0;
        end else if (!fetch_en) begin
            iss_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            if (mem_rd_en) begin
                iss_cnt <= iss_cnt + 1'b1;
            end
            if (ret_ok) begin
                ret_cnt <= ret_cnt + 1'b1;
            end
        end
    end

    // Each returned word lands in the register selected by its return index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mean   <= '0;
            prec   <= '0;
            weight <= '0;
            factor <= '0;
        end else if (ret_ok) begin
            for (int i = 0; i < FEAT_SIZE; i++) begin
                if (ret_cnt == CW'(OFF_MEAN + i)) begin
                    mean[32*i +: 32] <= mem_rdata;
                end
                if (ret_cnt == CW'(off_prec(FEAT_SIZE) + i)) begin
                    prec[32*i +: 32] <= mem_rdata;
                end
            end
            if (ret_cnt == CW'(off_weight(FEAT_SIZE))) begin
                weight <= mem_rdata;
            end
            if (ret_cnt == CW'(off_factor(FEAT_SIZE))) begin
                factor <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/gmm_score_sequencer.sv
// gmm_score_sequencer -- feeder for the combinational GMM scoring core.
//
// Loads one feature vector, then for every senone walks every component:
// fetches its record (gmm_param_fetch), holds the core inputs for
// CORE_LAT+1 cycles and folds core_score_out back into the accumulator
// that drives core_score_in. One accumulated score per senone leaves on a
// valid/ready stream; done pulses after the last senone is accepted.
//
// Optional feature (macro GMM_SEQ_BEST_EN): adds best_score/best_idx, the
// largest senone score of the frame (lowest index on ties), valid at done.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      frame start pulse, honoured only when idle
//   feat_valid/ready/data      feature word stream, dimension 0 first
//   mem_rd_en/addr/rdata/rvalid parameter-memory read port
//   core_feature/mean/prec     packed vectors to the core
//   core_weight/factor         per-component scalars to the core
//   core_score_in/out          running score to / updated score from core
//   score_valid/ready/data/idx senone score stream
//   busy                       any state other than idle
//   done                       one-cycle end-of-frame pulse
module gmm_score_sequencer
    import gmm_pkg::*;
#(
    parameter int FEAT_SIZE   = FEAT_SIZE_DEF,
    parameter int COMP_SIZE   = COMP_SIZE_DEF,
    parameter int SENONE_SIZE = SENONE_SIZE_DEF,
    parameter int ADDR_W      = 24,
    parameter int CORE_LAT    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    feat_valid,
    input  logic [31:0]             feat_data,
    output logic                    feat_ready,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [31:0]             mem_rdata,
    input  logic                    mem_rvalid,
    output logic [32*FEAT_SIZE-1:0] core_feature,
    output logic [32*FEAT_SIZE-1:0] core_mean,
    output logic [32*FEAT_SIZE-1:0] core_prec,
    output logic [31:0]             core_weight,
    output logic [31:0]             core_factor,
    output logic [31:0]             core_score_in,
    input  logic [31:0]             core_score_out,
    output logic                    score_valid,
    input  logic                    score_ready,
    output logic [31:0]             score_data,
    output logic [15:0]             score_idx,
    output logic                    busy,
    output logic                    done
`ifdef GMM_SEQ_BEST_EN
    ,
    output logic [31:0]             best_score,
    output logic [15:0]             best_idx
`endif
);

    localparam int R   = rec_stride(FEAT_SIZE);
    localparam int FCW = $clog2(FEAT_SIZE + 1);
    localparam int LW  = $clog2(CORE_LAT + 2);
    localparam logic [ADDR_W-1:0] R_STEP = ADDR_W'(R);

    logic [2:0]               state;
    logic [32*FEAT_SIZE-1:0]  feat_q;
    logic [FCW-1:0]           feat_cnt;
    logic [4:0]               comp;
    logic [15:0]              senone;
    logic [LW-1:0]            lat_cnt;
    logic [31:0]              acc;
    logic [ADDR_W-1:0]        rec_base;
    logic                     done_q;

    logic fetch_en;
    logic fetch_done;
    logic feat_fire;
    logic core_last;
    logic out_fire;

    assign fetch_en  = (state == ST_FETCH);
    assign feat_fire = (state == ST_LOAD_FEAT) && feat_valid;
    assign core_last = (state == ST_CORE) && (lat_cnt == LW'(CORE_LAT));
    assign out_fire  = (state == ST_OUT) && score_ready;

    assign feat_ready    = (state == ST_LOAD_FEAT);
    assign busy          = (state != ST_IDLE);
    assign score_valid   = (state == ST_OUT);
    assign score_data    = score_valid ? acc : '0;
    assign score_idx     = senone;
    assign core_score_in = acc;
    assign core_feature  = feat_q;
    assign done          = done_q;

    gmm_param_fetch #(
        .FEAT_SIZE (FEAT_SIZE),
        .ADDR_W    (ADDR_W)
    ) u_fetch (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_en   (fetch_en),
        .base_addr  (rec_base),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .mean       (core_mean),
        .prec       (core_prec),
        .weight     (core_weight),
        .factor     (core_factor),
        .fetch_done (fetch_done)
    );

    // Frame sequencing. The record base advances by one stride per component
    // and carries straight on into the next senone, since records of
    // consecutive senones are contiguous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            feat_q   <= '0;
            feat_cnt <= '0;
            comp     <= '0;
            senone   <= '0;
            lat_cnt  <= '0;
            acc      <= LOG_ZERO;
            rec_base <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOAD_FEAT;
                        senone   <= '0;
                        comp     <= '0;
                        feat_cnt <= '0;
                        rec_base <= '0;
                        acc      <= LOG_ZERO;
                    end
                end
                ST_LOAD_FEAT: begin
                    if (feat_fire) begin
                        for (int i = 0; i < FEAT_SIZE; i++) begin
                            if (feat_cnt == FCW'(i)) begin
                                feat_q[32*i +: 32] <= feat_data;
                            end
                        end
                        feat_cnt <= feat_cnt + 1'b1;
                        if (feat_cnt == FCW'(FEAT_SIZE - 1)) begin
                            state <= ST_FETCH;
                            acc   <= LOG_ZERO;
                        end
                    end
                end
                ST_FETCH: begin
                    if (fetch_done) begin
                        state   <= ST_CORE;
                        lat_cnt <= '0;
                    end
                end
                ST_CORE: begin
                    if (core_last) begin
                        acc <= core_score_out;
                        if (comp != 5'(COMP_SIZE - 1)) begin
                            comp     <= comp + 1'b1;
                            rec_base <= rec_base + R_STEP;
                            state    <= ST_FETCH;
                        end else begin
                            state <= ST_OUT;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (score_ready) begin
                        if (senone != 16'(SENONE_SIZE - 1)) begin
                            senone   <= senone + 1'b1;
                            comp     <= '0;
                            acc      <= LOG_ZERO;
                            rec_base <= rec_base + R_STEP;
                            state    <= ST_FETCH;
                        end else begin
                            done_q <= 1'b1;
                            state  <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef GMM_SEQ_BEST_EN
    // Best-score tracker: a strict greater-than keeps the earlier senone
    // when two scores tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_score <= LOG_ZERO;
            best_idx   <= '0;
        end else if ((state == ST_IDLE) && start) begin
            best_score <= LOG_ZERO;
            best_idx   <= '0;
        end else if (out_fire && fp_gt(acc, best_score)) begin
            best_score <= acc;
            best_idx   <= senone;
        end
    end
`endif

endmodule

// File: tb/tb_gmm_score_sequencer.sv
// tb_gmm_score_sequencer -- self-checking bench for gmm_score_sequencer.
//
// Geometry: 29 features, 2 components, 2 senones, CORE_LAT 1.
// Memory word at address a is seed + a. The stub core registers
// (score_in, or 0 when score_in is LOG_ZERO) + mean[0] + prec[28] + weight
// + factor, captured one cycle before it is presented, so the sequencer
// only sees the right value if it honours the core latency. For record base
// b this adds 4*seed + 4*b + 174, giving senone s the score
// 8*seed + 960*s + 588.
module tb_gmm_score_sequencer;
    import gmm_pkg::*;

    localparam int F  = 29;
    localparam int C  = 2;
    localparam int S  = 2;
    localparam int AW = 24;
    localparam int R  = 2 * F + 2;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              feat_valid;
    logic [31:0]       feat_data;
    logic              feat_ready;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;
    logic [32*F-1:0]   core_feature;
    logic [32*F-1:0]   core_mean;
    logic [32*F-1:0]   core_prec;
    logic [31:0]       core_weight;
    logic [31:0]       core_factor;
    logic [31:0]       core_score_in;
    logic [31:0]       core_score_out;
    logic              score_valid;
    logic              score_ready;
    logic [31:0]       score_data;
    logic [15:0]       score_idx;
    logic              busy;
    logic              done;
`ifdef GMM_SEQ_BEST_EN
    logic [31:0]       best_score;
    logic [15:0]       best_idx;
`endif

    gmm_score_sequencer #(
        .FEAT_SIZE   (F),
        .COMP_SIZE   (C),
        .SENONE_SIZE (S),
        .ADDR_W      (AW),
        .CORE_LAT    (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .feat_valid     (feat_valid),
        .feat_data      (feat_data),
        .feat_ready     (feat_ready),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .mem_rvalid     (mem_rvalid),
        .core_feature   (core_feature),
        .core_mean      (core_mean),
        .core_prec      (core_prec),
        .core_weight    (core_weight),
        .core_factor    (core_factor),
        .core_score_in  (core_score_in),
        .core_score_out (core_score_out),
        .score_valid    (score_valid),
        .score_ready    (score_ready),
        .score_data     (score_data),
        .score_idx      (score_idx),
        .busy           (busy),
        .done           (done)
`ifdef GMM_SEQ_BEST_EN
        ,
        .best_score     (best_score),
        .best_idx       (best_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [1023:0] actual,
                               input logic [1023:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Memory responder: records every issued read, returns data in order
    // after `lat` cycles, optionally only on random cycles.
    typedef struct {
        logic [AW-1:0] addr;
        int unsigned   due;
    } req_t;

    req_t          pend[$];
    logic [AW-1:0] addr_log[$];
    logic [31:0]   seed = 32'h0;
    int            lat  = 3;
    bit            gaps = 1'b0;
    bit            flush = 1'b0;
    int unsigned   cyc  = 0;

    function automatic logic [31:0] fw(input logic [31:0] s, input int k);
        return s ^ (32'hC0DE0000 + 32'(k));
    endfunction

    initial begin
        req_t r;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (mem_rd_en && rst_n) begin
                r.addr = mem_addr;
                r.due  = cyc + 32'(lat);
                pend.push_back(r);
                addr_log.push_back(mem_addr);
            end
            if (flush) begin
                pend.delete();
            end else if (pend.size() > 0 && pend[0].due <= cyc &&
                         (!gaps || $urandom_range(0, 1) == 1)) begin
                mem_rvalid = 1'b1;
                mem_rdata  = seed + 32'(pend[0].addr);
                void'(pend.pop_front());
            end
        end
    end

    // Stub core with one cycle of latency.
    initial begin
        logic [31:0] nxt;
        core_score_out = '0;
        forever begin
            @(negedge clk);
            nxt = ((core_score_in == LOG_ZERO) ? 32'h0 : core_score_in) +
                  core_mean[31:0] + core_prec[32*(F-1) +: 32] +
                  core_weight + core_factor;
            @(posedge clk);
            #1 core_score_out = nxt;
        end
    end

    // Every accumulator update is one core evaluation; the registers the
    // core saw must hold record number `evals`.
    int          evals = 0;
    int          dones = 0;
    logic [31:0] prev_acc = LOG_ZERO;

    initial begin
        logic [32*F-1:0] exp_mean;
        logic [32*F-1:0] exp_prec;
        logic [31:0]     b;
        forever begin
            @(negedge clk);
            if (core_score_in !== prev_acc && core_score_in !== LOG_ZERO) begin
                b = seed + 32'(evals * R);
                for (int d = 0; d < F; d++) begin
                    exp_mean[32*d +: 32] = b + 32'(d);
                    exp_prec[32*d +: 32] = b + 32'(F + d);
                end
                checkOutput("rec_mean", core_mean, exp_mean);
                checkOutput("rec_prec", core_prec, exp_prec);
                checkOutput("rec_weight", core_weight, b + 32'(2 * F));
                checkOutput("rec_factor", core_factor, b + 32'(2 * F + 1));
                evals++;
            end
            if (done === 1'b1) dones++;
            prev_acc = core_score_in;
        end
    end

    typedef struct {
        logic [31:0] seed;
        bit          gaps;
        int          lat;
        int          stall;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic [31:0] exp_best;
        logic [15:0] exp_best_idx;
    } vec_t;

    vec_t vecs[3];

    task automatic waitValid(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (score_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput(name, 1'b0, 1'b1);
    endtask

    task automatic loadFeatures(input logic [31:0] s, input bit toggle);
        for (int k = 0; k < F; k++) begin
            if (toggle) begin
                feat_valid = 1'b0;
                repeat ($urandom_range(0, 1)) @(negedge clk);
            end
            feat_valid = 1'b1;
            feat_data  = fw(s, k);
            @(negedge clk);
        end
        feat_valid = 1'b0;
        feat_data  = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        bit              ok;
        bit              stable;
        bit              order_ok;
        logic [32*F-1:0] exp_feat;
        seed  = v.seed;
        gaps  = v.gaps;
        lat   = v.lat;
        addr_log.delete();
        evals = 0;
        dones = 0;
        score_ready = (v.stall == 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("feat_ready_load", feat_ready, 1'b1);
        loadFeatures(v.seed, v.gaps);
        for (int k = 0; k < F; k++) exp_feat[32*k +: 32] = fw(v.seed, k);
        checkOutput("core_feature", core_feature, exp_feat);
        checkOutput("feat_ready_after", feat_ready, 1'b0);
        // A start pulse while busy must not restart the frame.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        waitValid("timeout_senone0", ok);
        if (!ok) return;
        checkOutput("score_idx0", score_idx, 16'd0);
        checkOutput("score_data0", score_data, v.exp0);
        if (v.stall > 0) begin
            stable = 1'b1;
            repeat (v.stall) begin
                @(negedge clk);
                if (score_valid !== 1'b1 || score_data !== v.exp0 ||
                    score_idx !== 16'd0 || mem_rd_en !== 1'b0) stable = 1'b0;
            end
            checkOutput("stall_stable", stable, 1'b1);
            score_ready = 1'b1;
        end
        @(negedge clk);
        checkOutput("next_fetch", {mem_rd_en, mem_addr}, {1'b1, 24'd120});

        waitValid("timeout_senone1", ok);
        if (!ok) return;
        checkOutput("score_idx1", score_idx, 16'd1);
        checkOutput("score_data1", score_data, v.exp1);
        @(negedge clk);
        checkOutput("done_pulse", {done, busy}, 2'b10);
        repeat (3) @(negedge clk);
        checkOutput("done_count", 32'(dones), 32'd1);
        checkOutput("core_evals", 32'(evals), 32'd4);
        checkOutput("addr_count", 32'(addr_log.size()), 32'(4 * R));
        order_ok = (addr_log.size() == 4 * R);
        for (int i = 0; i < addr_log.size(); i++) begin
            if (addr_log[i] !== AW'(i)) order_ok = 1'b0;
        end
        checkOutput("addr_order", order_ok, 1'b1);
`ifdef GMM_SEQ_BEST_EN
        checkOutput("best_score", best_score, v.exp_best);
        checkOutput("best_idx", best_idx, v.exp_best_idx);
`endif
    endtask

    // Reset in the middle of a fetch, then let the stale reads come back.
    task automatic resetMidFetch();
        seed  = 32'h55;
        gaps  = 1'b0;
        lat   = 5;
        score_ready = 1'b1;
        addr_log.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        loadFeatures(32'h55, 1'b0);
        for (int i = 0; i < 500; i++) begin
            if (addr_log.size() >= 10) break;
            @(negedge clk);
        end
        checkOutput("rst_issued", 32'(addr_log.size()), 32'd10);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_rd_en", mem_rd_en, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_acc", core_score_in, LOG_ZERO);
        checkOutput("rst_mean", core_mean, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("stray_busy", {busy, mem_rd_en, done}, 3'b000);
        checkOutput("stray_mean", core_mean, '0);
        checkOutput("stray_prec", core_prec, '0);
        checkOutput("stray_acc", core_score_in, LOG_ZERO);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        feat_valid  = 1'b0;
        feat_data   = '0;
        score_ready = 1'b1;

        vecs[0] = '{32'h00000000, 1'b0, 3, 0,  32'h0000024C, 32'h0000060C,
                    32'h0000060C, 16'd1};
        vecs[1] = '{32'h10000000, 1'b0, 3, 50, 32'h8000024C, 32'h8000060C,
                    32'h8000024C, 16'd0};
        vecs[2] = '{32'h00000010, 1'b1, 0, 0,  32'h000002CC, 32'h0000068C,
                    32'h0000068C, 16'd1};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_ctrl", {busy, mem_rd_en, feat_ready, score_valid, done},
                    5'b00000);
        checkOutput("reset_acc", core_score_in, LOG_ZERO);
        checkOutput("reset_addr", mem_addr, '0);
        checkOutput("reset_score", {score_data, score_idx}, '0);
        checkOutput("reset_params", {core_mean, core_prec, core_weight, core_factor}, '0);
        checkOutput("reset_feature", core_feature, '0);

        for (int i = 0; i < 3; i++) begin
            $display("[TB] vector %0d seed %0h", i, vecs[i].seed);
            applyStimulus(vecs[i]);
        end

        resetMidFetch();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gmm_score_sequencer.md
Name: gmm_score_sequencer

Overview:
- Initiator/feeder for the combinational GMM scoring core.
- Loads one feature vector, then walks every senone and every component in that senone.
- For each component it fetches means, precisions, weight and factor from parameter memory, drives the core, and feeds the core's score_out back as score_in (log-add accumulation).
- Emits one accumulated score per senone over a valid/ready stream. Sits between the parameter-memory/host side and the core.

Parameters:
- FEAT_SIZE, 29, feature dimensions per vector.
- COMP_SIZE, 32, Gaussian components per senone.
- SENONE_SIZE, 5120, senones per frame.
- ADDR_W, 24, parameter memory word-address width.
- CORE_LAT, 1, cycles from core inputs stable to score_out sampled (0 = same-cycle combinational).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  one-cycle pulse, begin a frame (ignored unless IDLE)
- feat_valid  in  1  feature word valid
- feat_data  in  32  feature word, dimension 0 first
- feat_ready  out  1  high in LOAD_FEAT
- mem_rd_en  out  1  read request
- mem_addr  out  ADDR_W  word address
- mem_rdata  in  32  read data
- mem_rvalid  in  1  read data valid; in order; any latency
- core_feature  out  32*FEAT_SIZE  feature vector, dim i at [32i+31:32i]
- core_mean  out  32*FEAT_SIZE  means
- core_prec  out  32*FEAT_SIZE  precisions
- core_weight  out  32  component weight
- core_factor  out  32  component factor
- core_score_in  out  32  running senone score
- core_score_out  in  32  updated score
- score_valid  out  1  senone score available
- score_ready  in  1  consumer accepts
- score_data  out  32  senone score (IEEE-754)
- score_idx  out  16  senone index of score_data
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after the last senone is accepted

Behaviour:
- Reset values:
  - All outputs 0.
  - Feature, mean and precision registers 0.
  - Accumulator = logZero (32'hFF7FFFFF).
  - State IDLE.
  - Reset asserted mid-operation aborts immediately: no further mem_rd_en; any in-flight rvalid after reset is ignored.
- Memory layout:
  - Record stride R = 2*FEAT_SIZE+2 words (60 at default).
  - Record base = (senone*COMP_SIZE + comp)*R.
  - Offsets: means 0..FEAT_SIZE-1, precs FEAT_SIZE..2*FEAT_SIZE-1, weight 2*FEAT_SIZE, factor 2*FEAT_SIZE+1.
- States:
  - IDLE: start -> LOAD_FEAT; senone = comp = 0.
  - LOAD_FEAT: accept FEAT_SIZE words on feat_valid&&feat_ready, stored in order. After the last word -> FETCH; accumulator = logZero.
  - FETCH: issue R reads, one per cycle, consecutive addresses; mem_rd_en is deasserted after the R-th issue. Count mem_rvalid returns and route each word by return count. When all R words have returned -> CORE.
  - CORE: core inputs are held stable for CORE_LAT+1 cycles; in the final cycle, accumulator <= core_score_out. Then:
    - comp < COMP_SIZE-1: comp++, -> FETCH.
    - otherwise: -> OUT.
  - OUT: score_valid=1 with score_data = accumulator and score_idx = senone, held stable until score_ready. On the handshake cycle:
    - senone < SENONE_SIZE-1: senone++, comp=0, accumulator=logZero, -> FETCH.
    - otherwise: done pulse, -> IDLE.
- core_score_in = accumulator at all times.
- Boundaries:
  - Returns are counted, never assumed; rvalid arriving on the same cycle as an issue is legal.
  - An excess rvalid while not in FETCH is ignored.
  - Backpressure on score_ready stalls the sequencer indefinitely with no memory traffic.
  - start while busy is ignored.
  - Address arithmetic uses full width; record base is computed incrementally (+R per component), with no multiplier.
- Counters: comp 5 bits, senone 16 bits, word counters sized for R.

Optional Feature:
- GMM_SEQ_BEST_EN:
  - Defined: adds outputs best_score[31:0] and best_idx[15:0], reset to logZero/0. Tracks the maximum senone score by signed IEEE compare (sign-magnitude; -0 == +0). Ties keep the lower index. Cleared at start; valid when done pulses.
  - Undefined: these ports and their logic are absent.

Decomposition:
- Package gmm_pkg holds the shared constants so core and sequencer agree:
  - LOG_ZERO = 32'hFF7FFFFF.
  - FEAT_SIZE, COMP_SIZE, SENONE_SIZE defaults.
  - Record offset constants.
  - State enum.
- One sub-module, gmm_param_fetch: issues R reads from a base address, counts returns, and writes the mean/prec/weight/factor registers.

Test Plan:
- Reset mid-FETCH (after 10 reads issued, 5 returned) -> state IDLE, mem_rd_en=0, accumulator 32'hFF7FFFFF; a later stray rvalid changes nothing.
- SENONE_SIZE=2, COMP_SIZE=2, memory rvalid latency 3 -> addresses 0..59, 60..119, 120..179, 180..239 in order; exactly 4 core evaluations; score_idx 0 then 1; done pulses once.
- Stub core returning score_in+1.0: first senone score = logZero+1.0 pattern after the first component; then 2 components -> model-computed value, and the accumulator resets to logZero between senones.
- score_ready held low 50 cycles -> score_data/score_idx stable, mem_rd_en=0 throughout; release -> next senone fetch starts the following cycle.
- Random mem_rvalid gaps (50% duty), FEAT_SIZE words with feat_valid toggling -> core_mean dim k equals word k of the record for every component.
- GMM_SEQ_BEST_EN: senone scores -5.0, -2.0, -2.0, -9.0 -> best_score=32'hC0000000, best_idx=1.
